// File: rtl/crypt_host_loader.sv
// Host-side sequencer around the encryption core: takes a command and an
// operand byte stream from the host, writes the operands into data memory,
// runs the core (start is a held-reset input), then streams the result
// region back to the host in ascending address order.
module crypt_host_loader #(
  parameter int START_CYC  = 2,
  parameter int TIMEOUT    = 16384,
  parameter int MSG_LEN    = 41,
  parameter int CRYPT_BASE = 64,
  parameter int CRYPT_LEN  = 64
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       core_start,
  input  logic       core_done,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC + 1) : 1;

  // Encrypt loads message + pre_length + taps + LFSR init at 0.., reads the
  // crypt region back; decrypt is the mirror image.
  localparam logic [6:0]    ENC_WLEN  = 7'(MSG_LEN + 3);
  localparam logic [6:0]    DEC_WLEN  = 7'(CRYPT_LEN);
  localparam logic [6:0]    ENC_RLEN  = 7'(CRYPT_LEN);
  localparam logic [6:0]    DEC_RLEN  = 7'(MSG_LEN);
  localparam logic [7:0]    CBASE     = 8'(CRYPT_BASE);
  localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SLAST     = SW'(START_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, RD_REQ, RD_WAIT, SEND
  } state_t;

  state_t        state, state_nx;
  logic          mode;            // 0 = encrypt, 1 = decrypt
  logic [6:0]    cnt;             // operand bytes written
  logic [6:0]    rcnt;            // result bytes delivered
  logic [SW-1:0] scnt;            // cycles spent in START
  logic [TW-1:0] tcnt;            // cycles spent in RUN

  logic [6:0]    wlen, rlen;
  logic [7:0]    wbase, rbase;
  logic          timeout_hit;

  assign wlen  = mode ? DEC_WLEN : ENC_WLEN;
  assign wbase = mode ? CBASE    : 8'd0;
  assign rlen  = mode ? DEC_RLEN : ENC_RLEN;
  assign rbase = mode ? 8'd0     : CBASE;

  // done wins over an expiring timer in the same cycle
  assign timeout_hit = (state == RUN) && !core_done && (tcnt == TLAST);

  // state register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state and all combinational handshake / memory / core outputs
  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 8'd0;
    mem_wdata  = 8'd0;
    core_start = 1'b1;            // core stays in reset unless running or draining
    busy       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = wbase + {1'b0, cnt};
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          if (cnt == wlen - 7'd1) state_nx = START;
        end
      end
      START: begin
        if (scnt == SLAST) state_nx = RUN;
      end
      RUN: begin
        core_start = 1'b0;
        if (core_done)        state_nx = RD_REQ;
        else if (timeout_hit) state_nx = IDLE;
      end
      RD_REQ: begin
        core_start = 1'b0;
        mem_addr   = rbase + {1'b0, rcnt};
        state_nx   = RD_WAIT;
      end
      RD_WAIT: begin
        core_start = 1'b0;
        mem_addr   = rbase + {1'b0, rcnt};
        state_nx   = SEND;
      end
      SEND: begin
        core_start = 1'b0;
        if (out_ready) state_nx = out_last ? IDLE : RD_REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  // counters, latched mode, sticky error and the registered output byte
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      mode        <= 1'b0;
      cnt         <= 7'd0;
      rcnt        <= 7'd0;
      scnt        <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mode        <= cmd_mode;
            timeout_err <= 1'b0;
            cnt         <= 7'd0;
          end
        end
        LOAD: begin
          scnt <= '0;
          if (in_valid) cnt <= cnt + 7'd1;
        end
        START: begin
          scnt <= scnt + SW'(1);
          tcnt <= '0;
        end
        RUN: begin
          tcnt <= tcnt + TW'(1);
          rcnt <= 7'd0;
          if (timeout_hit) timeout_err <= 1'b1;
        end
        RD_WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          out_last  <= (rcnt == rlen - 7'd1);
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rcnt      <= rcnt + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crypt_host_loader.sv
// Randomized bench for crypt_host_loader: a host driver, a memory/core model
// and one per-cycle compare process checking writes and result bytes
// against transaction-level expectations.
module tb_crypt_host_loader;

  localparam int START_CYC  = 2;
  localparam int TIMEOUT    = 100;
  localparam int MSG_LEN    = 41;
  localparam int CRYPT_BASE = 64;
  localparam int CRYPT_LEN  = 64;

  logic       CLK = 1'b0, reset_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_mode = 1'b0, cmd_ready;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'd0;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       core_start;
  logic       core_done = 1'b0;
  logic       out_valid, out_last, busy, timeout_err;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  crypt_host_loader #(
    .START_CYC(START_CYC), .TIMEOUT(TIMEOUT), .MSG_LEN(MSG_LEN),
    .CRYPT_BASE(CRYPT_BASE), .CRYPT_LEN(CRYPT_LEN)
  ) dut (
    .CLK(CLK), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_start(core_start), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected traffic
  logic [15:0] wq[$];            // {addr, data} writes still owed
  logic [8:0]  oq[$];            // {last, data} result bytes still owed
  logic [7:0]  dat[$];           // operand bytes for the next command
  logic [7:0]  res[$];           // core result bytes for the next command
  logic [7:0]  rmem [0:255];     // memory as the core leaves it
  logic [7:0]  wlog [0:255];     // last byte the DUT wrote per address
  logic [7:0]  olog [0:127];     // bytes delivered in the current command
  int          oidx = 0, ncmd = 0;
  int          done_delay = -1, rcyc = 0;

  // data memory: synchronous read, result region owned by the core model
  always @(posedge CLK) mem_rdata <= rmem[mem_addr];

  // core: done rises done_delay cycles into the run, drops when held in reset
  always @(negedge CLK) begin
    if (!reset_n || core_start) begin
      core_done = 1'b0;
      rcyc = 0;
    end else begin
      if (rcyc == done_delay) core_done = 1'b1;
      rcyc++;
    end
  end

  // per-cycle compare against owed writes and owed result bytes
  logic       held = 1'b0, hlast = 1'b0;
  logic [7:0] hdata = 8'd0;
  logic [15:0] w;
  logic [8:0]  o;
  always @(negedge CLK) begin
    chk("we_vs_handshake", 32'(mem_we), 32'(in_valid && in_ready));
    if (mem_we) begin
      if (wq.size() == 0) chk("we_unexpected", 32'(mem_we), 32'd0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(w[15:8]));
        chk("wr_data", 32'(mem_wdata), 32'(w[7:0]));
        wlog[mem_addr] = mem_wdata;
      end
    end
    if (out_valid) begin
      if (oq.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
      else begin
        if (held) begin
          chk("hold_data", 32'(out_data), 32'(hdata));
          chk("hold_last", 32'(out_last), 32'(hlast));
        end
        if (out_ready) begin
          o = oq.pop_front();
          chk("out_data", 32'(out_data), 32'(o[7:0]));
          chk("out_last", 32'(out_last), 32'(o[8]));
          if (oidx < 128) olog[oidx] = out_data;
          oidx++;
        end
      end
    end else if (held) chk("valid_dropped", 32'(out_valid), 32'd1);
    held  = out_valid && !out_ready;
    hdata = out_data;
    hlast = out_last;
    if (cmd_valid && cmd_ready) ncmd++;
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // command handshake with junk data bytes offered alongside
  task automatic send_cmd(input logic m);
    bit ok = 0;
    int g = 0;
    cmd_valid = 1'b1; cmd_mode = m; in_valid = 1'b1; in_data = 8'($urandom);
    while (!ok && g < 50) begin
      @(negedge CLK); ok = cmd_ready;
      step(); g++;
    end
    cmd_valid = 1'b0; in_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 32'd1);
    chk("terr_clear", 32'(timeout_err), 32'd0);
  endtask

  // stream dat[0..stop-1] with random gaps
  task automatic load(input int stop);
    int i = 0, g = 0;
    bit acc;
    while (i < stop && g < 1000) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = in_valid ? dat[i] : 8'($urandom);
      @(negedge CLK); acc = in_valid && in_ready;
      step();
      if (acc) i++;
      g++;
    end
    in_valid = 1'b0;
    chk("load_count", 32'(i), 32'(stop));
  endtask

  // one full command; delay >= TIMEOUT or < 0 means the core never finishes in time
  task automatic txn(input logic m, input int delay);
    int wlen, wbase, rlen, rbase, c0, g;
    bit to;
    wlen  = m ? CRYPT_LEN : MSG_LEN + 3;
    wbase = m ? CRYPT_BASE : 0;
    rlen  = m ? MSG_LEN : CRYPT_LEN;
    rbase = m ? 0 : CRYPT_BASE;
    to    = (delay < 0) || (delay >= TIMEOUT);
    if (dat.size() != wlen) begin dat.delete(); repeat (wlen) dat.push_back(8'($urandom)); end
    if (res.size() != rlen) begin res.delete(); repeat (rlen) res.push_back(8'($urandom)); end
    for (int i = 0; i < wlen; i++) wq.push_back({8'(wbase + i), dat[i]});
    for (int i = 0; i < rlen; i++) begin
      rmem[rbase + i] = res[i];
      if (!to) oq.push_back({(i == rlen - 1), res[i]});
    end
    done_delay = delay; oidx = 0; c0 = ncmd;
    send_cmd(m);
    load(wlen);
    in_valid = 1'b1; in_data = 8'($urandom);   // ignored outside LOAD
    for (int k = 0; k < START_CYC; k++) begin
      @(negedge CLK); chk("start_hi", 32'(core_start), 32'd1);
    end
    @(negedge CLK); chk("start_rel", 32'(core_start), 32'd0);
    if (to) begin
      for (int k = 1; k < TIMEOUT; k++) begin
        @(negedge CLK);
        chk("run_lo", 32'(core_start), 32'd0);
        chk("run_noerr", 32'(timeout_err), 32'd0);
      end
      @(negedge CLK);
      chk("timeout_err", 32'(timeout_err), 32'd1);
      chk("to_start", 32'(core_start), 32'd1);
      chk("to_idle", 32'(busy), 32'd0);
      step();
    end else begin
      step(); g = 0;
      while ((oq.size() != 0 || busy) && g < 3000) begin
        out_ready = 1'($urandom);
        cmd_valid = busy; cmd_mode = 1'($urandom);   // must be ignored while busy
        in_valid  = busy; in_data = 8'($urandom);
        step(); g++;
      end
      cmd_valid = 1'b0;
      chk("drain", 32'(oq.size()), 32'd0);
      chk("idle", 32'(busy), 32'd0);
      chk("out_count", 32'(oidx), 32'(rlen));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("cmds_taken", 32'(ncmd), 32'(c0 + 1));
    dat.delete(); res.delete();
  endtask

  initial begin
    string s;
    for (int i = 0; i < 256; i++) rmem[i] = 8'd0;

    // reset values
    @(negedge CLK);
    chk("rst_core_start", 32'(core_start), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    step(); reset_n = 1'b1; step();

    // reset in the middle of a load
    repeat (MSG_LEN + 3) dat.push_back(8'($urandom));
    for (int i = 0; i < MSG_LEN + 3; i++) wq.push_back({8'(i), dat[i]});
    send_cmd(1'b0);
    load(10);
    in_valid = 1'b1; reset_n = 1'b0;
    @(negedge CLK);
    chk("mid_rst_start", 32'(core_start), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    wq.delete(); dat.delete();
    step(); reset_n = 1'b1; in_valid = 1'b0;
    @(negedge CLK);
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_core_start", 32'(core_start), 32'd1);
    step();

    // directed encrypt
    s = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < s.len(); i++) dat.push_back(s[i]);
    dat.push_back(8'h09); dat.push_back(8'hd4); dat.push_back(8'h5c);
    for (int i = 0; i < CRYPT_LEN; i++) res.push_back(8'(8'h80 + i));
    txn(1'b0, 60);
    chk("pin_w0", 32'(wlog[0]), 32'h4d);
    chk("pin_w41", 32'(wlog[41]), 32'h09);
    chk("pin_w43", 32'(wlog[43]), 32'h5c);
    chk("pin_o0", 32'(olog[0]), 32'h80);
    chk("pin_o63", 32'(olog[63]), 32'hbf);

    // directed decrypt, done already high on the first run cycle
    s = "Knowledge comes, but wisdom lingers.     ";
    for (int i = 0; i < s.len(); i++) res.push_back(s[i]);
    txn(1'b1, 0);
    chk("pin_o0_dec", 32'(olog[0]), 32'h4b);
    chk("pin_o40_dec", 32'(olog[40]), 32'h20);
    chk("pin_w64_dec", 32'(wq.size()), 32'd0);

    // timeout, then done on the very last allowed cycle
    txn(1'b0, TIMEOUT);
    txn(1'b1, TIMEOUT - 1);

    // random commands
    for (int t = 0; t < 8; t++)
      txn(1'($urandom), ($urandom_range(4) == 0) ? -1 : int'($urandom_range(TIMEOUT - 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
